alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 143 ++++++++++++++
 tb/tb_alu_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshake and an
// accumulator that can replace operand A. Stage 1 holds the accepted request;
// stage 2 holds the computed result and flags that drive the outputs.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic             acc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] alu_o,
  output logic [3:0]       flags_o
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SLL = 3'd2,
    OP_SRL = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_SLT = 3'd7
  } op_e;

  // stage 1: registered request
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s1_acc;

  // stage 2: registered result
  logic             s2_valid;
  logic [WIDTH-1:0] s2_res;
  logic [3:0]       s2_flags;

  logic [WIDTH-1:0] acc_q;

  logic             adv;

  // combinational compute of stage 1
  logic [WIDTH-1:0] op_a;
  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic             shift_big;
  logic [WIDTH-1:0] res;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  // The whole pipe moves together; it only stalls when a result is waiting
  // and the consumer is not taking it.
  assign adv        = !s2_valid || out_ready_i;
  assign in_ready_o = adv;

  assign out_valid_o = s2_valid;
  assign alu_o       = s2_res;
  assign flags_o     = s2_flags;

  // Compute result and flags for the request held in stage 1.
  // acc_q is written on the same edge a result enters stage 2, so it already
  // holds the previous accepted result when the next request computes here;
  // no bypass path is needed for back-to-back accumulator use.
  always_comb begin
    op_a    = s1_acc ? acc_q : s1_a;
    sum_add = {1'b0, op_a} + {1'b0, s1_b};
    sum_sub = {1'b0, op_a} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, 1'b1};
    // Any amount >= WIDTH clears the result; the upper bits catch large
    // amounts, the compare catches non-power-of-two widths.
    shift_big = (|s1_b[WIDTH-1:SHW]) || (32'(s1_b[SHW-1:0]) >= WIDTH);
    res    = '0;
    flag_c = 1'b0;
    flag_v = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res    = sum_add[WIDTH-1:0];
        flag_c = sum_add[WIDTH];
        flag_v = (op_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                 (res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        res    = sum_sub[WIDTH-1:0];
        flag_c = sum_sub[WIDTH];
        flag_v = (op_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                 (res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SLL: res = shift_big ? '0 : (op_a << s1_b[SHW-1:0]);
      OP_SRL: res = shift_big ? '0 : (op_a >> s1_b[SHW-1:0]);
      OP_AND: res = op_a & s1_b;
      OP_OR:  res = op_a | s1_b;
      OP_XOR: res = op_a ^ s1_b;
      OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(s1_b))};
      default: res = '0;
    endcase
    flag_n = res[WIDTH-1];
    flag_z = (res == '0);
  end

  // Stage 1 register: captures the offered request whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s1_acc   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid_i;
      s1_a     <= a_i;
      s1_b     <= b_i;
      s1_op    <= op_e'(op_i);
      s1_acc   <= acc_i;
    end
  end

  // Stage 2 register and accumulator: bubbles pass through without
  // touching acc_q.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_flags <= 4'b0000;
      acc_q    <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_res   <= res;
      s2_flags <= {flag_n, flag_z, flag_c, flag_v};
      if (s1_valid) begin
        acc_q <= res;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): reset behaviour, flag vectors,
// back-to-back accumulator chaining, output stall and reset with a full pipe.
module tb_alu_pipe;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SLL = 3'd2;
  localparam logic [2:0] OP_SRL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic [2:0] op_i;
  logic       acc_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] alu_o;
  logic [3:0] flags_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pipe #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .op_i        (op_i),
    .acc_i       (acc_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .alu_o       (alu_o),
    .flags_o     (flags_o)
  );

  // free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic acc);
    in_valid_i = 1'b1;
    op_i       = op;
    a_i        = a;
    b_i        = b;
    acc_i      = acc;
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
    op_i       = 3'd0;
    a_i        = 8'h00;
    b_i        = 8'h00;
    acc_i      = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %4b expected %4b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // single request through an otherwise empty pipe, out_ready_i held high
  task automatic run_one(input string tag, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic acc,
                         input logic [7:0] exp_res, input logic [3:0] exp_flags);
    drive(op, a, b, acc);
    tick();
    idle();
    chk1({tag, "_lat"}, out_valid_o, 1'b0);
    tick();
    chk1({tag, "_vld"}, out_valid_o, 1'b1);
    chk8({tag, "_res"}, alu_o, exp_res);
    chk4({tag, "_flg"}, flags_o, exp_flags);
    tick();
  endtask

  // directed sequence
  initial begin
    reset_n     = 1'b0;
    out_ready_i = 1'b1;
    idle();

    // reset state
    tick();
    tick();
    chk1("rst_vld", out_valid_o, 1'b0);
    chk8("rst_res", alu_o, 8'h00);
    chk4("rst_flg", flags_o, 4'b0000);
    chk1("rst_rdy", in_ready_o, 1'b1);

    // request offered in the reset cycle must be dropped; the first edge out
    // of reset accepts ADD 0x50+0x58 normally
    drive(OP_ADD, 8'h01, 8'h01, 1'b0);
    tick();
    reset_n = 1'b1;
    run_one("add_ovf", OP_ADD, 8'h50, 8'h58, 1'b0, 8'hA8, 4'b1001);

    run_one("sub_neg",  OP_SUB, 8'h58, 8'h78, 1'b0, 8'hE0, 4'b1000);
    run_one("sub_zero", OP_SUB, 8'h78, 8'h78, 1'b0, 8'h00, 4'b0110);
    run_one("sub_ovf",  OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0011);
    run_one("add_wrap", OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110);
    run_one("sll",      OP_SLL, 8'h81, 8'h01, 1'b0, 8'h02, 4'b0000);
    run_one("sll_big",  OP_SLL, 8'hFF, 8'h08, 1'b0, 8'h00, 4'b0100);
    run_one("srl_big",  OP_SRL, 8'hFF, 8'h09, 1'b0, 8'h00, 4'b0100);
    run_one("srl",      OP_SRL, 8'hF0, 8'h04, 1'b0, 8'h0F, 4'b0000);
    run_one("slt",      OP_SLT, 8'h80, 8'h01, 1'b0, 8'h01, 4'b0000);
    run_one("slt_no",   OP_SLT, 8'h01, 8'h80, 1'b0, 8'h00, 4'b0100);
    run_one("xor",      OP_XOR, 8'hA5, 8'hFF, 1'b0, 8'h5A, 4'b0000);
    run_one("or",       OP_OR,  8'h80, 8'h01, 1'b0, 8'h81, 4'b1000);

    // back-to-back accumulator chain after a fresh reset
    reset_n = 1'b0;
    idle();
    tick();
    reset_n = 1'b1;
    drive(OP_ADD, 8'hAA, 8'h01, 1'b1);
    tick();
    drive(OP_ADD, 8'hAA, 8'h01, 1'b1);
    tick();
    chk1("b2b0_vld", out_valid_o, 1'b1);
    chk8("b2b0_res", alu_o, 8'h01);
    drive(OP_ADD, 8'hAA, 8'h01, 1'b1);
    tick();
    chk8("b2b1_res", alu_o, 8'h02);
    drive(OP_AND, 8'hF0, 8'h3C, 1'b0);
    tick();
    chk8("b2b2_res", alu_o, 8'h03);
    drive(OP_ADD, 8'h00, 8'h01, 1'b1);
    tick();
    chk8("b2b_and", alu_o, 8'h30);
    idle();
    tick();
    chk1("b2b_acc_vld", out_valid_o, 1'b1);
    chk8("b2b_acc_res", alu_o, 8'h31);
    tick();
    chk1("b2b_drain", out_valid_o, 1'b0);

    // output stall: 4 cycles with out_ready_i low, 3 requests offered
    out_ready_i = 1'b0;
    drive(OP_XOR, 8'h0F, 8'hFF, 1'b0);
    chk1("st_rdy0", in_ready_o, 1'b1);
    tick();
    chk1("st_rdy1", in_ready_o, 1'b1);
    drive(OP_OR, 8'h12, 8'h21, 1'b0);
    tick();
    chk1("st_vld2", out_valid_o, 1'b1);
    chk8("st_res2", alu_o, 8'hF0);
    chk1("st_rdy2", in_ready_o, 1'b0);
    drive(OP_SUB, 8'h10, 8'h01, 1'b0);
    tick();
    chk8("st_res3", alu_o, 8'hF0);
    chk4("st_flg3", flags_o, 4'b1000);
    chk1("st_rdy3", in_ready_o, 1'b0);
    tick();
    chk8("st_res4", alu_o, 8'hF0);
    chk1("st_rdy4", in_ready_o, 1'b0);
    out_ready_i = 1'b1;
    #1;
    chk1("st_rel_rdy", in_ready_o, 1'b1);
    tick();
    idle();
    chk1("st_d1_vld", out_valid_o, 1'b1);
    chk8("st_d1_res", alu_o, 8'h33);
    tick();
    chk1("st_d2_vld", out_valid_o, 1'b1);
    chk8("st_d2_res", alu_o, 8'h0F);
    chk4("st_d2_flg", flags_o, 4'b0010);
    tick();
    chk1("st_d3_vld", out_valid_o, 1'b0);
    run_one("st_acc", OP_ADD, 8'h00, 8'h01, 1'b1, 8'h10, 4'b0000);

    // reset with both stages full
    out_ready_i = 1'b0;
    drive(OP_ADD, 8'h01, 8'h02, 1'b0);
    tick();
    drive(OP_ADD, 8'h03, 8'h04, 1'b0);
    tick();
    idle();
    chk1("full_vld", out_valid_o, 1'b1);
    chk8("full_res", alu_o, 8'h03);
    reset_n = 1'b0;
    #1;
    chk1("full_rst_rdy", in_ready_o, 1'b0);
    tick();
    chk1("fr_vld", out_valid_o, 1'b0);
    chk8("fr_res", alu_o, 8'h00);
    chk4("fr_flg", flags_o, 4'b0000);
    chk1("fr_rdy", in_ready_o, 1'b1);
    reset_n     = 1'b1;
    out_ready_i = 1'b1;
    tick();
    chk1("fr_s1_gone", out_valid_o, 1'b0);
    run_one("fr_acc", OP_ADD, 8'hEE, 8'h05, 1'b1, 8'h05, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
